// File: rtl/flash_line_buffer.sv
// flash_line_buffer: single-line read cache in front of the flash adapter.
// One aligned line of LineWords words is kept locally. A miss refills the
// whole line downstream starting with the requested (critical) word, and the
// upstream read is answered as soon as that word arrives. Writes get an error.
module flash_line_buffer #(
    parameter int unsigned LineWords = 4,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdWidth   = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 sbr_req_i,
    output logic                 sbr_gnt_o,
    input  logic [AddrWidth-1:0] sbr_addr_i,
    input  logic                 sbr_we_i,
    input  logic [3:0]           sbr_be_i,
    input  logic [DataWidth-1:0] sbr_wdata_i,
    input  logic [IdWidth-1:0]   sbr_aid_i,
    output logic                 sbr_rvalid_o,
    output logic [DataWidth-1:0] sbr_rdata_o,
    output logic                 sbr_err_o,
    output logic [IdWidth-1:0]   sbr_rid_o,
    output logic                 mgr_req_o,
    input  logic                 mgr_gnt_i,
    output logic [AddrWidth-1:0] mgr_addr_o,
    output logic                 mgr_we_o,
    output logic [3:0]           mgr_be_o,
    input  logic                 mgr_rvalid_i,
    input  logic [DataWidth-1:0] mgr_rdata_i,
    input  logic                 mgr_err_i
);
    localparam int unsigned IdxW = $clog2(LineWords);
    localparam int unsigned TagW = AddrWidth - 2 - IdxW;

    typedef enum logic [1:0] {IDLE, FILL_REQ, FILL_WAIT} state_e;

    state_e                              r_state;
    logic [LineWords-1:0]                r_valid;
    logic [LineWords-1:0][DataWidth-1:0] r_data;
    logic [TagW-1:0]                     r_tag;
    logic [IdxW-1:0]                     r_ptr;
    logic [IdxW-1:0]                     r_cnt;
    logic                                r_flush_pend;
    logic                                r_resp_pend;
    logic                                r_rvalid;
    logic                                r_err;
    logic [DataWidth-1:0]                r_rdata;
    logic [IdWidth-1:0]                  r_aid;

    logic            w_hs;
    logic [IdxW-1:0] w_idx;
    logic [TagW-1:0] w_tag;
    logic            w_hit;
    logic            w_last;
    logic            w_crit;
    logic            w_unused;

    // Byte enables, write data and the sub-word address bits carry no meaning here.
    assign w_unused = ^{sbr_be_i, sbr_wdata_i, sbr_addr_i[1:0]};

    // Only one upstream transaction in flight; reset forces the grant low.
    assign sbr_gnt_o = rst_ni && sbr_req_i && (r_state == IDLE) && !r_resp_pend;
    assign w_hs      = sbr_gnt_o;
    assign w_idx     = sbr_addr_i[2+IdxW-1:2];
    assign w_tag     = sbr_addr_i[AddrWidth-1:2+IdxW];
    // A flush in the handshake cycle turns a would-be hit into a miss.
    assign w_hit     = (w_tag == r_tag) && r_valid[w_idx] && !flush_i;
    assign w_last    = (r_cnt == IdxW'(LineWords - 1));
    assign w_crit    = (r_cnt == '0);

    assign sbr_rvalid_o = r_rvalid;
    assign sbr_rdata_o  = r_rdata;
    assign sbr_err_o    = r_err;
    assign sbr_rid_o    = r_aid;
    assign mgr_req_o    = (r_state == FILL_REQ);
    assign mgr_addr_o   = {r_tag, r_ptr, 2'b00};
    assign mgr_we_o     = 1'b0;
    assign mgr_be_o     = 4'hF;

    // Control FSM, line storage and registered upstream response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_valid      <= '0;
            r_data       <= '0;
            r_tag        <= '0;
            r_ptr        <= '0;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
            r_resp_pend  <= 1'b0;
            r_rvalid     <= 1'b0;
            r_err        <= 1'b0;
            r_rdata      <= '0;
            r_aid        <= '0;
        end else begin
            // Responses are single-cycle pulses; data/err read as zero otherwise.
            r_rvalid    <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_resp_pend <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (flush_i) r_valid <= '0;
                    if (w_hs) begin
                        r_aid <= sbr_aid_i;
                        if (sbr_we_i) begin
                            r_rvalid <= 1'b1;
                            r_err    <= 1'b1;
                        end else if (w_hit) begin
                            r_rvalid <= 1'b1;
                            r_rdata  <= r_data[w_idx];
                        end else begin
                            r_valid      <= '0;
                            r_tag        <= w_tag;
                            r_ptr        <= w_idx;
                            r_cnt        <= '0;
                            r_flush_pend <= 1'b0;
                            r_state      <= FILL_REQ;
                        end
                    end
                end
                FILL_REQ: begin
                    if (flush_i) r_flush_pend <= 1'b1;
                    if (mgr_gnt_i) r_state <= FILL_WAIT;
                end
                FILL_WAIT: begin
                    if (flush_i) r_flush_pend <= 1'b1;
                    if (mgr_rvalid_i) begin
                        if (mgr_err_i) begin
                            // Abort: drop the partial line; only the critical word owes a reply.
                            r_valid      <= '0;
                            r_flush_pend <= 1'b0;
                            r_state      <= IDLE;
                            if (w_crit) begin
                                r_rvalid    <= 1'b1;
                                r_err       <= 1'b1;
                                r_resp_pend <= 1'b1;
                            end
                        end else begin
                            r_data[r_ptr]  <= mgr_rdata_i;
                            r_valid[r_ptr] <= 1'b1;
                            if (w_crit) begin
                                r_rvalid    <= 1'b1;
                                r_rdata     <= mgr_rdata_i;
                                r_resp_pend <= 1'b1;
                            end
                            r_ptr <= r_ptr + 1'b1;
                            r_cnt <= r_cnt + 1'b1;
                            if (w_last) begin
                                r_state <= IDLE;
                                // A flush seen during the fill invalidates the line once complete.
                                if (r_flush_pend || flush_i) begin
                                    r_valid      <= '0;
                                    r_flush_pend <= 1'b0;
                                end
                            end else begin
                                r_state <= FILL_REQ;
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
